// File: rtl/pwm_sched_pkg.sv
// Shared definitions for the PWM command scheduler: FSM encoding and command record layout.
package pwm_sched_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StLoad     = 3'd1,
      StWaitIdle = 3'd2,
      StStart    = 3'd3,
      StAck      = 3'd4
   } sched_state_e;

   // Command record: {ch, duty, pulse_num, pat}, channel in the top byte.
   localparam int unsigned CmdW     = 56;
   localparam int unsigned PatLsb   = 0;
   localparam int unsigned PatW     = 32;
   localparam int unsigned PulseLsb = 32;
   localparam int unsigned PulseW   = 8;
   localparam int unsigned DutyLsb  = 40;
   localparam int unsigned DutyW    = 8;
   localparam int unsigned ChLsb    = 48;
   localparam int unsigned ChW      = 8;

   function automatic logic [CmdW-1:0] pack_cmd(input logic [ChW-1:0]    ch,
                                                input logic [DutyW-1:0]  duty,
                                                input logic [PulseW-1:0] pulse_num,
                                                input logic [PatW-1:0]   pat);
      return {ch, duty, pulse_num, pat};
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with fall-through read data, full/empty flags and occupancy level.
module cmd_fifo #(
   parameter int unsigned Width = 56,
   parameter int unsigned Depth = 4,
   localparam int unsigned AddrW = $clog2(Depth),
   localparam int unsigned LvlW  = AddrW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LvlW-1:0]  level_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q;
   logic [AddrW-1:0] rd_ptr_q;
   logic [LvlW-1:0]  level_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (level_q == LvlW'(Depth));
   assign empty_o = (level_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage array; not reset, contents are only meaningful below level_q.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AddrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AddrW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + LvlW'(1);
            2'b01:   level_q <= level_q - LvlW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/pwm_cmd_scheduler.sv
// Queues channel commands and issues them in order to the PWM cores, waiting for each target
// channel to go idle (with a timeout) before pulsing its start line.
module pwm_cmd_scheduler import pwm_sched_pkg::*; #(
   parameter int unsigned _NUM_CHANNELS = 6,
   parameter int unsigned _FIFO_DEPTH   = 4,
   parameter int unsigned _TIMEOUT      = 50000,
   localparam int unsigned LvlW = $clog2(_FIFO_DEPTH) + 1
) (
   input  logic                     clk_50M,
   input  logic                     sys_rst,
   input  logic                     cmd_valid,
   input  logic [7:0]               cmd_ch,
   input  logic [7:0]               cmd_duty,
   input  logic [7:0]               cmd_pulse_num,
   input  logic [31:0]              cmd_pat,
   output logic                     cmd_ready,
   input  logic [_NUM_CHANNELS-1:0] pwm_busy,
   output logic [_NUM_CHANNELS-1:0] ch_start,
   output logic [7:0]               ch_duty,
   output logic [7:0]               ch_pulse_num,
   output logic [31:0]              ch_pat,
   output logic                     cmd_drop,
   output logic                     timeout_err,
   output logic [LvlW-1:0]          fifo_level,
   output logic                     sched_busy
);

   localparam int unsigned       CntW   = $clog2(_TIMEOUT + 1);
   localparam logic [CntW-1:0]   CntMax = CntW'(_TIMEOUT - 1);
   localparam logic [8:0]        NumCh  = 9'(_NUM_CHANNELS);

   sched_state_e             state_q;
   logic [ChW-1:0]           cfg_ch_q;
   logic [DutyW-1:0]         duty_q;
   logic [PulseW-1:0]        pulse_q;
   logic [PatW-1:0]          pat_q;
   logic [CntW-1:0]          to_cnt_q;
   logic [1:0]               ack_cnt_q;
   logic [_NUM_CHANNELS-1:0] ch_start_q;
   logic                     timeout_q;
   logic                     drop_q;

   logic                     ch_ok;
   logic                     push;
   logic                     pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CmdW-1:0]          head;
   logic [_NUM_CHANNELS-1:0] ch_oh;
   logic                     busy_sel;

   assign ch_ok = ({1'b0, cmd_ch} < NumCh);
   // Fullness is the registered level, so a same-cycle pop never makes room for a push.
   assign push  = cmd_valid & ch_ok & ~fifo_full;
   assign pop   = (state_q == StLoad);

   cmd_fifo #(
      .Width (CmdW),
      .Depth (_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk_i   (clk_50M),
      .rst_i   (sys_rst),
      .push_i  (push),
      .wdata_i (pack_cmd(cmd_ch, cmd_duty, cmd_pulse_num, cmd_pat)),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Decode the latched channel index and pick out its busy flag.
   always_comb begin
      ch_oh = '0;
      for (int unsigned i = 0; i < _NUM_CHANNELS; i++) begin
         ch_oh[i] = (cfg_ch_q == ChW'(i));
      end
      busy_sel = |(pwm_busy & ch_oh);
   end

   // Scheduler FSM with registered start/timeout pulses and config bus.
   always_ff @(posedge clk_50M) begin
      if (sys_rst) begin
         state_q    <= StIdle;
         cfg_ch_q   <= '0;
         duty_q     <= '0;
         pulse_q    <= '0;
         pat_q      <= '0;
         to_cnt_q   <= '0;
         ack_cnt_q  <= '0;
         ch_start_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         ch_start_q <= '0;
         timeout_q  <= 1'b0;
         unique case (state_q)
            // A push accepted this cycle counts as non-empty to save a cycle of latency.
            StIdle: begin
               if (!fifo_empty || push) begin
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               cfg_ch_q <= head[ChLsb +: ChW];
               duty_q   <= head[DutyLsb +: DutyW];
               pulse_q  <= head[PulseLsb +: PulseW];
               pat_q    <= head[PatLsb +: PatW];
               to_cnt_q <= '0;
               state_q  <= StWaitIdle;
            end
            StWaitIdle: begin
               if (!busy_sel) begin
                  ch_start_q <= ch_oh;
                  state_q    <= StStart;
               end else if (to_cnt_q == CntMax) begin
                  timeout_q <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  to_cnt_q <= to_cnt_q + CntW'(1);
               end
            end
            StStart: begin
               ack_cnt_q <= '0;
               state_q   <= StAck;
            end
            StAck: begin
               if (busy_sel || ack_cnt_q == 2'd3) begin
                  state_q <= StIdle;
               end else begin
                  ack_cnt_q <= ack_cnt_q + 2'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Rejection pulse lands one cycle after the offending strobe.
   always_ff @(posedge clk_50M) begin
      if (sys_rst) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= cmd_valid & ~push;
      end
   end

   // Status outputs are forced to their idle values while reset is held.
   assign ch_start     = sys_rst ? '0 : ch_start_q;
   assign cmd_drop     = drop_q & ~sys_rst;
   assign timeout_err  = timeout_q & ~sys_rst;
   assign cmd_ready    = sys_rst | ~fifo_full;
   assign sched_busy   = ~sys_rst & ((state_q != StIdle) | ~fifo_empty);
   assign ch_duty      = duty_q;
   assign ch_pulse_num = pulse_q;
   assign ch_pat       = pat_q;

endmodule

// File: tb/tb_pwm_cmd_scheduler.sv
// Self-checking bench for pwm_cmd_scheduler: directed scenarios plus a randomized run against a
// queue-based ordering model with a simple PWM-core busy model.
module tb_pwm_cmd_scheduler;

   logic        clk_50M = 1'b0;
   logic        sys_rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_ch = '0;
   logic [7:0]  cmd_duty = '0;
   logic [7:0]  cmd_pulse_num = '0;
   logic [31:0] cmd_pat = '0;
   logic [5:0]  pwm_busy = '0;

   logic        cmd_ready, cmd_drop, timeout_err, sched_busy;
   logic [5:0]  ch_start;
   logic [7:0]  ch_duty, ch_pulse_num;
   logic [31:0] ch_pat;
   logic [2:0]  fifo_level;

   logic        t_cmd_ready, t_cmd_drop, t_timeout_err, t_sched_busy;
   logic [5:0]  t_ch_start;
   logic [7:0]  t_ch_duty, t_ch_pulse_num;
   logic [31:0] t_ch_pat;
   logic [2:0]  t_fifo_level;

   int checks = 0;
   int failures = 0;

   always #10 clk_50M = ~clk_50M;

   pwm_cmd_scheduler u_dut (
      .clk_50M       (clk_50M),
      .sys_rst       (sys_rst),
      .cmd_valid     (cmd_valid),
      .cmd_ch        (cmd_ch),
      .cmd_duty      (cmd_duty),
      .cmd_pulse_num (cmd_pulse_num),
      .cmd_pat       (cmd_pat),
      .cmd_ready     (cmd_ready),
      .pwm_busy      (pwm_busy),
      .ch_start      (ch_start),
      .ch_duty       (ch_duty),
      .ch_pulse_num  (ch_pulse_num),
      .ch_pat        (ch_pat),
      .cmd_drop      (cmd_drop),
      .timeout_err   (timeout_err),
      .fifo_level    (fifo_level),
      .sched_busy    (sched_busy)
   );

   // Short-timeout instance sharing all inputs; only the timeout scenario checks it.
   pwm_cmd_scheduler #(._TIMEOUT(20)) u_dut_to (
      .clk_50M       (clk_50M),
      .sys_rst       (sys_rst),
      .cmd_valid     (cmd_valid),
      .cmd_ch        (cmd_ch),
      .cmd_duty      (cmd_duty),
      .cmd_pulse_num (cmd_pulse_num),
      .cmd_pat       (cmd_pat),
      .cmd_ready     (t_cmd_ready),
      .pwm_busy      (pwm_busy),
      .ch_start      (t_ch_start),
      .ch_duty       (t_ch_duty),
      .ch_pulse_num  (t_ch_pulse_num),
      .ch_pat        (t_ch_pat),
      .cmd_drop      (t_cmd_drop),
      .timeout_err   (t_timeout_err),
      .fifo_level    (t_fifo_level),
      .sched_busy    (t_sched_busy)
   );

   task automatic do_reset();
      @(negedge clk_50M);
      sys_rst = 1'b1;
      cmd_valid = 1'b0;
      pwm_busy = '0;
      @(negedge clk_50M);
      @(negedge clk_50M);
      sys_rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] ch, input logic [7:0] duty, input logic [7:0] pn,
                       input logic [31:0] pat);
      cmd_valid = 1'b1;
      cmd_ch = ch;
      cmd_duty = duty;
      cmd_pulse_num = pn;
      cmd_pat = pat;
   endtask

   task automatic test_reset();
      @(negedge clk_50M);
      sys_rst = 1'b1;
      cmd_valid = 1'b0;
      pwm_busy = '0;
      @(negedge clk_50M);
      @(negedge clk_50M);
      checks++; if (ch_start !== 6'b0) begin failures++;
         $display("FAIL reset_ch_start got=%b exp=000000", ch_start); end
      checks++; if (cmd_drop !== 1'b0) begin failures++;
         $display("FAIL reset_cmd_drop got=%b exp=0", cmd_drop); end
      checks++; if (timeout_err !== 1'b0) begin failures++;
         $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
      checks++; if (cmd_ready !== 1'b1) begin failures++;
         $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (sched_busy !== 1'b0) begin failures++;
         $display("FAIL reset_sched_busy got=%b exp=0", sched_busy); end
      checks++; if (fifo_level !== 3'd0) begin failures++;
         $display("FAIL reset_fifo_level got=%0d exp=0", fifo_level); end
      checks++; if ({ch_duty, ch_pulse_num, ch_pat} !== 48'd0) begin failures++;
         $display("FAIL reset_cfg got=%h/%h/%h exp=0", ch_duty, ch_pulse_num, ch_pat); end
      sys_rst = 1'b0;
   endtask

   task automatic test_single();
      int n;
      do_reset();
      send(8'd2, 8'h40, 8'd5, 32'hA5A5A5A5);
      @(negedge clk_50M);
      cmd_valid = 1'b0;
      checks++; if (ch_start !== 6'b0 || fifo_level !== 3'd1 || sched_busy !== 1'b1) begin
         failures++; $display("FAIL single_t1 got start=%b lvl=%0d busy=%b exp=000000/1/1",
                              ch_start, fifo_level, sched_busy); end
      @(negedge clk_50M);
      checks++; if (ch_start !== 6'b0) begin failures++;
         $display("FAIL single_t2 got=%b exp=000000", ch_start); end
      @(negedge clk_50M);
      checks++; if (ch_start !== 6'b000100) begin failures++;
         $display("FAIL single_start got=%b exp=000100", ch_start); end
      checks++; if (ch_duty !== 8'h40 || ch_pulse_num !== 8'd5 || ch_pat !== 32'hA5A5A5A5) begin
         failures++; $display("FAIL single_bus got=%h/%h/%h exp=40/05/a5a5a5a5",
                              ch_duty, ch_pulse_num, ch_pat); end
      checks++; if (fifo_level !== 3'd0) begin failures++;
         $display("FAIL single_level got=%0d exp=0", fifo_level); end
      @(negedge clk_50M);
      checks++; if (ch_start !== 6'b0) begin failures++;
         $display("FAIL single_pulse_width got=%b exp=000000", ch_start); end
      checks++; if (ch_duty !== 8'h40) begin failures++;
         $display("FAIL single_hold got=%h exp=40", ch_duty); end
      n = 0;
      while (sched_busy && n < 20) begin @(negedge clk_50M); n++; end
      checks++; if (sched_busy !== 1'b0) begin failures++;
         $display("FAIL single_drain got sched_busy=%b exp=0", sched_busy); end
   endtask

   task automatic test_busy_channel();
      int to_seen = 0;
      int early = 0;
      do_reset();
      pwm_busy = 6'b000010;
      send(8'd1, 8'h11, 8'd3, 32'h12345678);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_50M);
         cmd_valid = 1'b0;
         if (ch_start !== 6'b0) early++;
         if (timeout_err) to_seen++;
      end
      checks++; if (early !== 0) begin failures++;
         $display("FAIL busy_early_start got=%0d exp=0", early); end
      pwm_busy = 6'b0;
      @(negedge clk_50M);
      checks++; if (ch_start !== 6'b000010) begin failures++;
         $display("FAIL busy_release_start got=%b exp=000010", ch_start); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_50M);
         if (timeout_err) to_seen++;
      end
      checks++; if (to_seen !== 0) begin failures++;
         $display("FAIL busy_timeout got=%0d exp=0", to_seen); end
   endtask

   task automatic test_timeout();
      int to_cnt = 0;
      int to_at = -1;
      int st_at = -1;
      int bad = 0;
      logic [7:0] st_duty = '0;
      do_reset();
      pwm_busy = 6'b001000;
      send(8'd3, 8'h33, 8'd1, 32'h0);
      @(negedge clk_50M);
      send(8'd0, 8'h11, 8'd2, 32'h1);
      for (int k = 2; k < 40; k++) begin
         @(negedge clk_50M);
         cmd_valid = 1'b0;
         if (t_timeout_err) begin to_cnt++; to_at = k; end
         if (t_ch_start[3]) bad++;
         if (t_ch_start == 6'b000001 && st_at < 0) begin st_at = k; st_duty = t_ch_duty; end
      end
      pwm_busy = 6'b0;
      checks++; if (to_cnt !== 1) begin failures++;
         $display("FAIL timeout_count got=%0d exp=1", to_cnt); end
      checks++; if (to_at !== 22) begin failures++;
         $display("FAIL timeout_cycle got=%0d exp=22", to_at); end
      checks++; if (bad !== 0) begin failures++;
         $display("FAIL timeout_start_issued got=%0d exp=0", bad); end
      checks++; if (st_at !== 25 || st_duty !== 8'h11) begin failures++;
         $display("FAIL timeout_next_cmd got cycle=%0d duty=%h exp=25/11", st_at, st_duty); end
   endtask

   task automatic test_overflow();
      int drops = 0;
      logic [7:0] exp_d [5];
      logic [7:0] got [$];
      logic       first_ch4 = 1'b0;
      do_reset();
      pwm_busy = 6'b010000;
      send(8'd4, 8'hA0, 8'd1, 32'hF0);
      @(negedge clk_50M);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk_50M);
      for (int i = 0; i < 6; i++) begin
         checks++; if (cmd_ready !== 1'(i < 4)) begin failures++;
            $display("FAIL ovf_ready[%0d] got=%b exp=%b", i, cmd_ready, 1'(i < 4)); end
         checks++; if (cmd_drop !== 1'(i >= 5)) begin failures++;
            $display("FAIL ovf_drop[%0d] got=%b exp=%b", i, cmd_drop, 1'(i >= 5)); end
         if (cmd_drop) drops++;
         send(8'd0, 8'(8'hB0 + i), 8'd2, 32'(i));
         @(negedge clk_50M);
      end
      cmd_valid = 1'b0;
      if (cmd_drop) drops++;
      checks++; if (cmd_drop !== 1'b1) begin failures++;
         $display("FAIL ovf_drop_last got=%b exp=1", cmd_drop); end
      checks++; if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin failures++;
         $display("FAIL ovf_full got lvl=%0d ready=%b exp=4/0", fifo_level, cmd_ready); end
      @(negedge clk_50M);
      if (cmd_drop) drops++;
      checks++; if (drops !== 2) begin failures++;
         $display("FAIL ovf_drop_count got=%0d exp=2", drops); end
      pwm_busy = 6'b0;
      exp_d[0] = 8'hA0;
      for (int i = 1; i < 5; i++) exp_d[i] = 8'(8'hAF + i);
      for (int c = 0; c < 200 && got.size() < 5; c++) begin
         @(negedge clk_50M);
         if (ch_start != 6'b0) begin
            if (got.size() == 0) first_ch4 = (ch_start == 6'b010000);
            got.push_back(ch_duty);
         end
      end
      checks++; if (got.size() !== 5 || !first_ch4) begin failures++;
         $display("FAIL ovf_issue got n=%0d first_ch4=%b exp=5/1", got.size(), first_ch4); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_d[i]) begin failures++;
            $display("FAIL ovf_order[%0d] got=%h exp=%h", i, got[i], exp_d[i]); end
      end
   endtask

   task automatic test_invalid();
      do_reset();
      send(8'd7, 8'h77, 8'd1, 32'h7);
      @(negedge clk_50M);
      cmd_valid = 1'b0;
      checks++; if (cmd_drop !== 1'b1 || fifo_level !== 3'd0) begin failures++;
         $display("FAIL inval_drop got drop=%b lvl=%0d exp=1/0", cmd_drop, fifo_level); end
      @(negedge clk_50M);
      checks++; if (cmd_drop !== 1'b0 || sched_busy !== 1'b0 || fifo_level !== 3'd0) begin
         failures++; $display("FAIL inval_after got drop=%b busy=%b lvl=%0d exp=0/0/0",
                              cmd_drop, sched_busy, fifo_level); end
   endtask

   task automatic test_reset_in_start();
      int starts = 0;
      do_reset();
      send(8'd5, 8'h55, 8'd9, 32'hDEADBEEF);
      @(negedge clk_50M);
      cmd_valid = 1'b0;
      @(negedge clk_50M);
      sys_rst = 1'b1;
      @(negedge clk_50M);
      checks++; if (ch_start !== 6'b0 || cmd_drop !== 1'b0 || timeout_err !== 1'b0) begin
         failures++; $display("FAIL rst_start_pulses got=%b/%b/%b exp=000000/0/0",
                              ch_start, cmd_drop, timeout_err); end
      checks++; if (cmd_ready !== 1'b1 || sched_busy !== 1'b0 || fifo_level !== 3'd0) begin
         failures++; $display("FAIL rst_start_status got=%b/%b/%0d exp=1/0/0",
                              cmd_ready, sched_busy, fifo_level); end
      checks++; if ({ch_duty, ch_pulse_num, ch_pat} !== 48'd0) begin failures++;
         $display("FAIL rst_start_cfg got=%h/%h/%h exp=0", ch_duty, ch_pulse_num, ch_pat); end
      sys_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_50M);
         if (ch_start != 6'b0) starts++;
      end
      checks++; if (starts !== 0) begin failures++;
         $display("FAIL rst_start_abandon got=%0d exp=0", starts); end
   endtask

   task automatic test_random();
      logic [55:0] exp_q [$];
      logic [55:0] hd;
      logic [5:0]  exp_oh;
      logic [7:0]  ch;
      int          busy_cnt [6];
      int          sent = 0;
      int          cyc = 0;
      logic        drop_pend = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) busy_cnt[i] = 0;
      while ((sent < 60 || exp_q.size() != 0) && cyc < 4000) begin
         @(negedge clk_50M);
         cyc++;
         checks++; if ($countones(ch_start) > 1) begin failures++;
            $display("FAIL rnd_onehot got=%b exp=at most one bit", ch_start); end
         checks++; if (cmd_drop !== drop_pend) begin failures++;
            $display("FAIL rnd_drop got=%b exp=%b", cmd_drop, drop_pend); end
         for (int i = 0; i < 6; i++) begin
            if (busy_cnt[i] > 0) busy_cnt[i]--;
            else if ($urandom_range(0, 31) == 0) busy_cnt[i] = $urandom_range(1, 10);
         end
         if (ch_start != 6'b0) begin
            checks++;
            if (exp_q.size() == 0) begin failures++;
               $display("FAIL rnd_unexpected_start got=%b exp=none", ch_start);
            end else begin
               hd = exp_q.pop_front();
               exp_oh = 6'b000001 << hd[55:48];
               if (ch_start !== exp_oh || ch_duty !== hd[47:40] || ch_pulse_num !== hd[39:32]
                   || ch_pat !== hd[31:0]) begin
                  failures++;
                  $display("FAIL rnd_issue got=%b/%h/%h/%h exp=%b/%h/%h/%h", ch_start, ch_duty,
                           ch_pulse_num, ch_pat, exp_oh, hd[47:40], hd[39:32], hd[31:0]);
               end
            end
            for (int i = 0; i < 6; i++) if (ch_start[i]) busy_cnt[i] = $urandom_range(1, 6);
         end
         for (int i = 0; i < 6; i++) pwm_busy[i] = (busy_cnt[i] > 0);
         cmd_valid = 1'b0;
         drop_pend = 1'b0;
         // At most three outstanding commands keeps the queue below full.
         if (sent < 60 && exp_q.size() <= 3 && $urandom_range(0, 2) == 0) begin
            ch = 8'($urandom_range(0, 7));
            send(ch, 8'($urandom), 8'($urandom), $urandom);
            sent++;
            if (ch < 8'd6) exp_q.push_back({ch, cmd_duty, cmd_pulse_num, cmd_pat});
            else drop_pend = 1'b1;
         end
      end
      cmd_valid = 1'b0;
      pwm_busy = 6'b0;
      checks++; if (exp_q.size() != 0 || cyc >= 4000) begin failures++;
         $display("FAIL rnd_drain got pending=%0d cycles=%0d exp=0/<4000", exp_q.size(), cyc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_busy_channel();
      test_timeout();
      test_overflow();
      test_invalid();
      test_reset_in_start();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_cmd_scheduler.md
PWM_CMD_SCHEDULER -- requirements
Module: pwm_cmd_scheduler

Interface
REQ-001 SHALL have parameter _NUM_CHANNELS, default 6: number of high-speed PWM channels scheduled.
REQ-002 SHALL have parameter _FIFO_DEPTH, default 4 (power of 2): command queue depth.
REQ-003 SHALL have parameter _TIMEOUT, default 50000: maximum cycles spent waiting for a busy channel.
REQ-004 SHALL have port clk_50M, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1: one-cycle command strobe from the UART register mapper.
REQ-007 SHALL have port cmd_ch, input, 8: target channel index.
REQ-008 SHALL have port cmd_duty, input, 8: duty number.
REQ-009 SHALL have port cmd_pulse_num, input, 8: pulse count.
REQ-010 SHALL have port cmd_pat, input, 32: pattern word.
REQ-011 SHALL have port cmd_ready, output, 1: high when the queue is not full.
REQ-012 SHALL have port pwm_busy, input, _NUM_CHANNELS: per-channel busy flags from the PWM cores.
REQ-013 SHALL have port ch_start, output, _NUM_CHANNELS: one-hot, one-cycle start pulse.
REQ-014 SHALL have port ch_duty, output, 8: shared configuration bus.
REQ-015 SHALL have port ch_pulse_num, output, 8: shared configuration bus.
REQ-016 SHALL have port ch_pat, output, 32: shared configuration bus.
REQ-017 SHALL have port cmd_drop, output, 1: one-cycle pulse when a command is rejected.
REQ-018 SHALL have port timeout_err, output, 1: one-cycle pulse when a queued command is abandoned.
REQ-019 SHALL have port fifo_level, output, $clog2(_FIFO_DEPTH)+1: current queue occupancy.
REQ-020 SHALL have port sched_busy, output, 1: high whenever the FSM is not IDLE or the queue is not empty.

Function
REQ-021 SHALL push {cmd_ch, cmd_duty, cmd_pulse_num, cmd_pat} into the queue when cmd_valid=1, cmd_ch<_NUM_CHANNELS and the queue is not full.
REQ-022 SHALL drop the command and pulse cmd_drop in the next cycle when cmd_valid=1 and either cmd_ch>=_NUM_CHANNELS or the queue is full; fullness is evaluated before any same-cycle pop.
REQ-023 SHALL implement FSM states IDLE, LOAD, WAIT_IDLE, START and ACK.
REQ-024 IDLE: go to LOAD when the queue is non-empty.
REQ-025 LOAD: pop the head entry into the config registers, clear the timeout counter, and go to WAIT_IDLE.
REQ-026 WAIT_IDLE: go to START when pwm_busy[ch]=0. Otherwise increment the counter; when it reaches _TIMEOUT-1, pulse timeout_err, discard the command and go to IDLE.
REQ-027 START: drive ch_start[ch]=1 for exactly this one cycle, then go to ACK.
REQ-028 ACK: go to IDLE when pwm_busy[ch]=1 or after 4 cycles in ACK, whichever comes first.
REQ-029 ch_duty, ch_pulse_num and ch_pat SHALL be registered, change only in LOAD, and hold stable from LOAD through ACK.
REQ-030 Latency: cmd_valid at cycle t, with an empty queue, FSM in IDLE and the channel idle, SHALL give ch_start high in cycle t+3.
REQ-031 Commands SHALL be issued strictly in arrival order; a blocked head blocks all later entries (no reordering).
REQ-032 fifo_level SHALL wrap-safely track pushes minus pops; simultaneous push and pop leaves the level unchanged.
REQ-033 At most one bit of ch_start SHALL be high in any cycle.

Reset
REQ-034 While sys_rst=1 at a clock edge, the block SHALL go to IDLE and clear queue pointers, fifo_level, the timeout counter and all config registers to 0.
REQ-035 During reset, ch_start, cmd_drop and timeout_err SHALL be 0, cmd_ready SHALL be 1 and sched_busy SHALL be 0.
REQ-036 Reset asserted mid-operation (any state) SHALL abandon the in-flight command without emitting ch_start.

Structure
REQ-037 Package pwm_sched_pkg SHALL hold the FSM state encoding, the command-record width (56 bits) and its field offsets.
REQ-038 The queue SHALL be a sub-module cmd_fifo (synchronous FIFO with full, empty and level outputs); the FSM stays in pwm_cmd_scheduler.

Verification
REQ-039 Single command: cmd_ch=2, duty=0x40, pulse_num=5, pat=0xA5A5A5A5, all channels idle -> ch_start=6'b000100 at t+3, bus carries 0x40/5/0xA5A5A5A5, fifo_level returns to 0.
REQ-040 Busy channel: pwm_busy[1]=1 for 100 cycles, command to ch1 -> ch_start[1] is asserted 1 cycle after pwm_busy[1] falls; timeout_err is never asserted.
REQ-041 Timeout: _TIMEOUT=20, pwm_busy[3] held at 1 -> timeout_err pulses once about 20 cycles after LOAD, no ch_start is issued, and the next queued command proceeds.
REQ-042 Overflow: 6 back-to-back commands while the FSM is blocked -> 4 are queued, cmd_drop pulses twice, cmd_ready=0 while full.
REQ-043 Invalid channel: cmd_ch=7 with _NUM_CHANNELS=6 -> cmd_drop pulses, fifo_level stays 0.
REQ-044 Reset in START: assert sys_rst in the cycle before START -> no ch_start is issued, and all outputs match their reset values the next cycle.
